// File: rtl/seq_mul8_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
package seq_mul8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PP0  = 3'd1,
    ST_PP1  = 3'd2,
    ST_PP2  = 3'd3,
    ST_PP3  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Left shift applied to each partial product before accumulation.
  localparam logic [3:0] PP0_SHIFT = 4'd0;
  localparam logic [3:0] PP1_SHIFT = 4'd4;
  localparam logic [3:0] PP2_SHIFT = 4'd4;
  localparam logic [3:0] PP3_SHIFT = 4'd8;

  // Value presented when the 17-bit accumulator overflows 16 bits.
  localparam logic [15:0] SAT_VALUE = 16'hFFFF;

  // Clamp the 17-bit accumulator to a 16-bit product.
  function automatic logic [15:0] sat16(input logic [16:0] acc);
    logic [15:0] res;
    if (acc[16]) begin
      res = SAT_VALUE;
    end else begin
      res = acc[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_mul8_ctrl_mul4_core.sv
// Purely combinational 4x4 multiplier core, exact or approximate.
// The approximate table forces the two LSBs of every non-zero product high,
// so its outputs can exceed the exact product (15*15 gives 227, not 225).
module mul4_core #(
  parameter bit APPROX = 1'b1
) (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] prod
);

  logic [7:0] exact_s;

  assign exact_s = {4'd0, x} * {4'd0, y};

  // Select exact product or the rounded-up approximate table entry.
  always_comb begin
    prod = exact_s;
    if (APPROX && (exact_s != 8'd0)) begin
      prod = {exact_s[7:2], 2'b11};
    end else begin
      prod = exact_s;
    end
  end

endmodule

// File: rtl/seq_mul8_ctrl.sv
// Sequential 8x8 multiplier: four nibble partial products through one
// shared 4x4 core, 17-bit accumulation, saturated 16-bit result with
// valid/ready handshakes on both sides.
module seq_mul8_ctrl
  import seq_mul8_ctrl_pkg::*;
#(
  parameter bit APPROX    = 1'b1,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy,
  output logic [15:0] ops_done
);

  state_t      state_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [16:0] acc_r;
  logic [15:0] p_r;
  logic        out_valid_r;
  logic        in_ready_r;
  logic        busy_r;
  logic [15:0] ops_done_r;

  logic [3:0]  core_x_s;
  logic [3:0]  core_y_s;
  logic [3:0]  shift_s;
  logic [7:0]  core_p_s;
  logic [16:0] pp_term_s;
  logic [16:0] acc_sum_s;

  mul4_core #(.APPROX(APPROX)) u_core (
    .x    (core_x_s),
    .y    (core_y_s),
    .prod (core_p_s)
  );

  // Pick operand nibbles and partial-product shift from the current state.
  always_comb begin
    core_x_s = 4'd0;
    core_y_s = 4'd0;
    shift_s  = 4'd0;
    case (state_r)
      ST_PP0: begin
        core_x_s = a_r[3:0];
        core_y_s = b_r[3:0];
        shift_s  = PP0_SHIFT;
      end
      ST_PP1: begin
        core_x_s = a_r[7:4];
        core_y_s = b_r[3:0];
        shift_s  = PP1_SHIFT;
      end
      ST_PP2: begin
        core_x_s = a_r[3:0];
        core_y_s = b_r[7:4];
        shift_s  = PP2_SHIFT;
      end
      ST_PP3: begin
        core_x_s = a_r[7:4];
        core_y_s = b_r[7:4];
        shift_s  = PP3_SHIFT;
      end
      default: begin
        core_x_s = 4'd0;
        core_y_s = 4'd0;
        shift_s  = 4'd0;
      end
    endcase
  end

  assign pp_term_s = {9'd0, core_p_s} << shift_s;
  assign acc_sum_s = acc_r + pp_term_s;

  // Controller FSM with all handshake and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= 8'd0;
      b_r         <= 8'd0;
      acc_r       <= 17'd0;
      p_r         <= 16'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      ops_done_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            acc_r      <= 17'd0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_PP0;
          end
        end
        ST_PP0: begin
          // A zero operand makes the product zero: skip the remaining passes.
          if (ZERO_SKIP && ((a_r == 8'd0) || (b_r == 8'd0))) begin
            acc_r       <= 17'd0;
            p_r         <= 16'd0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            acc_r   <= acc_sum_s;
            state_r <= ST_PP1;
          end
        end
        ST_PP1: begin
          acc_r   <= acc_sum_s;
          state_r <= ST_PP2;
        end
        ST_PP2: begin
          acc_r   <= acc_sum_s;
          state_r <= ST_PP3;
        end
        ST_PP3: begin
          acc_r       <= acc_sum_s;
          p_r         <= sat16(acc_sum_s);
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            ops_done_r  <= ops_done_r + 16'd1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign p         = p_r;
  assign busy      = busy_r;
  assign ops_done  = ops_done_r;

endmodule

// File: tb/tb_seq_mul8_ctrl.sv
// Self-checking bench: an approximate/zero-skip instance and an exact/no-skip
// instance share operands; results are compared with an arithmetic model.
module tb_seq_mul8_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ordy_x, ordy_e;
  logic        irdy_x, irdy_e;
  logic        ov_x, ov_e;
  logic [15:0] p_x, p_e;
  logic        busy_x, busy_e;
  logic [15:0] ops_x, ops_e;

  logic [15:0] exp_ops_x;
  logic [15:0] exp_ops_e;
  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  seq_mul8_ctrl #(.APPROX(1'b1), .ZERO_SKIP(1'b1)) dut_x (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy_x),
    .a(a), .b(b), .out_valid(ov_x), .out_ready(ordy_x), .p(p_x),
    .busy(busy_x), .ops_done(ops_x)
  );

  seq_mul8_ctrl #(.APPROX(1'b0), .ZERO_SKIP(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy_e),
    .a(a), .b(b), .out_valid(ov_e), .out_ready(ordy_e), .p(p_e),
    .busy(busy_e), .ops_done(ops_e)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Nibble product: exact, or approximate (non-zero products get their two LSBs set).
  function automatic int core_ref(input int x, input int y, input bit approx);
    int e;
    e = x * y;
    if (approx && e != 0) return (e / 4) * 4 + 3;
    return e;
  endfunction

  function automatic int ref_mul(input int av, input int bv, input bit approx, input bit zs);
    int acc;
    if (zs && (av == 0 || bv == 0)) return 0;
    acc = core_ref(av % 16, bv % 16, approx)
        + core_ref(av / 16, bv % 16, approx) * 16
        + core_ref(av % 16, bv / 16, approx) * 16
        + core_ref(av / 16, bv / 16, approx) * 256;
    return (acc > 65535) ? 65535 : acc;
  endfunction

  // One full transaction on both instances, with `hold` extra backpressure cycles.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold);
    int lat_x, lat_e, exp_lat_x;
    logic [15:0] px, pe;
    px = 16'd0;
    pe = 16'd0;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    check_eq("irdy_x_after_accept", {31'd0, irdy_x}, 32'd0);
    check_eq("busy_e_after_accept", {31'd0, busy_e}, 32'd1);
    // Operands change and in_valid stays high: both must be ignored.
    a = 8'($urandom); b = 8'($urandom);
    lat_x = 0; lat_e = 0;
    for (int n = 1; n <= 12 && (lat_x == 0 || lat_e == 0); n++) begin
      @(posedge clk); #1;
      if (lat_x == 0 && ov_x) begin lat_x = n; px = p_x; end
      if (lat_e == 0 && ov_e) begin lat_e = n; pe = p_e; end
    end
    exp_lat_x = (av == 8'd0 || bv == 8'd0) ? 1 : 4;
    check_eq("lat_x", lat_x, exp_lat_x);
    check_eq("lat_e", lat_e, 32'd4);
    check_eq("p_x", {16'd0, px}, ref_mul(av, bv, 1'b1, 1'b1));
    check_eq("p_e", {16'd0, pe}, ref_mul(av, bv, 1'b0, 1'b0));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_p_e", {16'd0, p_e}, {16'd0, pe});
      check_eq("hold_ov_e", {31'd0, ov_e}, 32'd1);
      check_eq("hold_irdy_e", {31'd0, irdy_e}, 32'd0);
      check_eq("hold_busy_e", {31'd0, busy_e}, 32'd1);
    end
    check_eq("held_p_x", {16'd0, p_x}, {16'd0, px});
    check_eq("held_ov_x", {31'd0, ov_x}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; ordy_x = 1'b1; ordy_e = 1'b1;
    @(posedge clk); #1;
    ordy_x = 1'b0; ordy_e = 1'b0;
    exp_ops_x = exp_ops_x + 16'd1;
    exp_ops_e = exp_ops_e + 16'd1;
    check_eq("ov_x_after_hs", {31'd0, ov_x}, 32'd0);
    check_eq("ov_e_after_hs", {31'd0, ov_e}, 32'd0);
    check_eq("irdy_e_after_hs", {31'd0, irdy_e}, 32'd1);
    check_eq("busy_x_after_hs", {31'd0, busy_x}, 32'd0);
    check_eq("ops_x", {16'd0, ops_x}, {16'd0, exp_ops_x});
    check_eq("ops_e", {16'd0, ops_e}, {16'd0, exp_ops_e});
  endtask

  function automatic logic [7:0] pick_operand();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 8'd0;
    if (r == 1) return 8'hF0 | 8'($urandom);
    return 8'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 8'd0; b = 8'd0;
    ordy_x = 1'b0; ordy_e = 1'b0;
    exp_ops_x = 16'd0; exp_ops_e = 16'd0;
    #12;
    check_eq("rst_ov", {31'd0, ov_x | ov_e}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_x | busy_e}, 32'd0);
    check_eq("rst_ops", {16'd0, ops_x | ops_e}, 32'd0);
    check_eq("rst_p", {16'd0, p_x | p_e}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_irdy", {30'd0, irdy_x, irdy_e}, 32'd3);

    // Directed corner cases.
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h00, 8'h5A, 2);
    run_op(8'h5A, 8'h00, 0);
    run_op(8'h12, 8'h34, 10);
    run_op(8'hF0, 8'h0F, 1);
    run_op(8'h01, 8'h01, 0);

    // Randomized traffic with variable backpressure.
    for (int i = 0; i < 40; i++) begin
      run_op(pick_operand(), pick_operand(), int'($urandom_range(0, 3)));
    end

    // Reset during PP2 discards the operation.
    @(negedge clk);
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_ops_x = 16'd0; exp_ops_e = 16'd0;
    check_eq("midrst_ov", {30'd0, ov_x, ov_e}, 32'd0);
    check_eq("midrst_ops_e", {16'd0, ops_e}, 32'd0);
    check_eq("midrst_ops_x", {16'd0, ops_x}, 32'd0);
    check_eq("midrst_busy", {30'd0, busy_x, busy_e}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_eq("postrst_irdy", {30'd0, irdy_x, irdy_e}, 32'd3);
    run_op(8'd3, 8'd5, 0);

    // Completion counter wraps from FFFF to 0.
    @(negedge clk);
    force dut_e.ops_done_r = 16'hFFFF;
    force dut_x.ops_done_r = 16'hFFFF;
    @(negedge clk);
    release dut_e.ops_done_r;
    release dut_x.ops_done_r;
    exp_ops_x = 16'hFFFF; exp_ops_e = 16'hFFFF;
    @(negedge clk);
    check_eq("preload_ops_e", {16'd0, ops_e}, 32'h0000FFFF);
    run_op(8'h07, 8'h09, 0);
    check_eq("wrap_ops_e", {16'd0, ops_e}, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
